// File: rtl/instr_mem_loader.sv
// Byte-stream loader for the 19-bit instruction memory: header (address, count) then 3 bytes per word.
// Optional trailing checksum byte when LOADER_CHECKSUM_EN is defined.
module instr_mem_loader #(
    parameter int ADDR_W  = 12,
    parameter int INSTR_W = 19
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               in_valid,
    input  logic [7:0]         in_data,
    output logic               in_ready,
    output logic               wr_en,
    output logic [ADDR_W-1:0]  wr_addr,
    output logic [INSTR_W-1:0] wr_data,
    output logic               busy,
    output logic               done,
    output logic               chk_err
);

    typedef enum logic [3:0] {
        S_IDLE, S_A_LO, S_A_HI, S_C_LO, S_C_HI,
        S_B0, S_B1, S_B2, S_WRITE, S_FIN
`ifdef LOADER_CHECKSUM_EN
        , S_CHK
`endif
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] cnt_q;   // words remaining minus one
    logic [7:0]        b0_q, b1_q;
    logic              hs;

    assign hs = in_valid & in_ready;

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // NOTE: every output is defaulted first so no path through the case infers a latch.
    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        wr_en    = 1'b0;
        busy     = 1'b1;
        done     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (start) state_d = S_A_LO;
            end
            S_A_LO: begin in_ready = 1'b1; if (in_valid) state_d = S_A_HI; end
            S_A_HI: begin in_ready = 1'b1; if (in_valid) state_d = S_C_LO; end
            S_C_LO: begin in_ready = 1'b1; if (in_valid) state_d = S_C_HI; end
            S_C_HI: begin in_ready = 1'b1; if (in_valid) state_d = S_B0;   end
            S_B0:   begin in_ready = 1'b1; if (in_valid) state_d = S_B1;   end
            S_B1:   begin in_ready = 1'b1; if (in_valid) state_d = S_B2;   end
            S_B2:   begin in_ready = 1'b1; if (in_valid) state_d = S_WRITE; end
            S_WRITE: begin
                wr_en = 1'b1;
                if (cnt_q != '0) state_d = S_B0;
`ifdef LOADER_CHECKSUM_EN
                else             state_d = S_CHK;
`else
                else             state_d = S_FIN;
`endif
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHK:  begin in_ready = 1'b1; if (in_valid) state_d = S_FIN; end
`endif
            S_FIN: begin
                busy    = 1'b0;
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: these are plain registers, not a memory array, so all of them take the reset value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q  <= '0;
            cnt_q   <= '0;
            b0_q    <= '0;
            b1_q    <= '0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            if (hs) begin
                unique case (state_q)
                    S_A_LO: addr_q[7:0]        <= in_data;
                    S_A_HI: addr_q[ADDR_W-1:8] <= in_data[ADDR_W-9:0];
                    S_C_LO: cnt_q[7:0]         <= in_data;
                    S_C_HI: cnt_q[ADDR_W-1:8]  <= in_data[ADDR_W-9:0];
                    S_B0:   b0_q               <= in_data;
                    S_B1:   b1_q               <= in_data;
                    S_B2: begin
                        // Word and address are latched together so they stay stable through WRITE and FIN.
                        wr_addr <= addr_q;
                        wr_data <= {in_data[INSTR_W-17:0], b1_q, b0_q};
                    end
                    default: ;
                endcase
            end
            if (state_q == S_WRITE) begin
                addr_q <= addr_q + 1'b1;
                cnt_q  <= cnt_q - 1'b1;
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] xor_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            xor_q   <= '0;
            chk_err <= 1'b0;
        end else begin
            if (state_q == S_IDLE && start) begin
                xor_q   <= '0;
                chk_err <= 1'b0;
            end else if (hs) begin
                xor_q <= xor_q ^ in_data;
                if (state_q == S_CHK) chk_err <= (in_data != xor_q);
            end
        end
    end
`else
    assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: table of load sessions plus reset-abort and checksum sequences.
module tb_instr_mem_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        wr_en;
    logic [11:0] wr_addr;
    logic [18:0] wr_data;
    logic        busy;
    logic        done;
    logic        chk_err;

    instr_mem_loader #(.ADDR_W(12), .INSTR_W(19)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .chk_err(chk_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0]      addr;
        logic [11:0]      cnt;
        logic [7:0]       hdr_hi;
        logic [7:0]       b2_hi;
        int               n;
        logic [2:0][18:0] word;
        logic [2:0][11:0] exp_addr;
        logic [2:0][18:0] exp_data;
        bit               gaps;
        bit               mid_start;
    } vec_t;

    int n_checks = 0;
    int n_pass   = 0;
    int done_cnt = 0;
    logic [11:0] wq_addr[$];
    logic [18:0] wq_data[$];
    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (wr_en) begin
            wq_addr.push_back(wr_addr);
            wq_data.push_back(wr_data);
            check("in_ready_low_in_write", {31'b0, in_ready}, 32'd0);
        end
        if (done) begin
            done_cnt++;
            check("busy_low_at_done", {31'b0, busy}, 32'd0);
        end
    end

    function automatic vec_t make_vec(input logic [11:0] a, input logic [11:0] c,
                                      input logic [7:0] hh, input logic [7:0] bh, input int n,
                                      input logic [18:0] w0, input logic [18:0] w1, input logic [18:0] w2,
                                      input logic [11:0] e0, input logic [11:0] e1, input logic [11:0] e2,
                                      input bit gaps, input bit mid);
        vec_t v;
        v.addr = a; v.cnt = c; v.hdr_hi = hh; v.b2_hi = bh; v.n = n;
        v.word[0] = w0; v.word[1] = w1; v.word[2] = w2;
        v.exp_addr[0] = e0; v.exp_addr[1] = e1; v.exp_addr[2] = e2;
        v.exp_data[0] = w0; v.exp_data[1] = w1; v.exp_data[2] = w2;
        v.gaps = gaps; v.mid_start = mid;
        return v;
    endfunction

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 50) check("in_ready_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic gap_cycles(input int g);
        in_valid = 1'b0;
        repeat (g) begin @(posedge clk); #1; end
    endtask

    task automatic run_session(input vec_t v, input bit bad_chk);
        logic [7:0]  bytes[$];
        logic [7:0]  x = 8'h00;
        logic [18:0] w;
        int          d0, t;
        bytes.push_back(v.addr[7:0]);
        bytes.push_back(v.hdr_hi | {4'h0, v.addr[11:8]});
        bytes.push_back(v.cnt[7:0]);
        bytes.push_back(v.hdr_hi | {4'h0, v.cnt[11:8]});
        for (int i = 0; i < v.n; i++) begin
            w = v.word[i];
            bytes.push_back(w[7:0]);
            bytes.push_back(w[15:8]);
            bytes.push_back(v.b2_hi | {5'b0, w[18:16]});
        end
        foreach (bytes[i]) x = x ^ bytes[i];
`ifdef LOADER_CHECKSUM_EN
        bytes.push_back(bad_chk ? (x ^ 8'hFF) : x);
`endif
        wq_addr.delete();
        wq_data.delete();
        d0 = done_cnt;
        pulse_start();
        foreach (bytes[i]) begin
            if (v.gaps) gap_cycles($urandom_range(0, 3));
            if (v.mid_start && (i == 3 || i == 6)) begin
                in_valid = 1'b0;
                pulse_start();
            end
            send_byte(bytes[i]);
        end
        in_valid = 1'b0;
        t = 0;
        while (done_cnt == d0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("done_pulse_count", done_cnt - d0, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic check_vec(input string tag, input vec_t v, input bit exp_chk);
        check({tag, "_nwrites"}, wq_addr.size(), v.n);
        for (int i = 0; i < v.n; i++) begin
            if (i < wq_addr.size()) begin
                check({tag, "_addr"}, {20'b0, wq_addr[i]}, {20'b0, v.exp_addr[i]});
                check({tag, "_data"}, {13'b0, wq_data[i]}, {13'b0, v.exp_data[i]});
            end
        end
        check({tag, "_hold_addr"}, {20'b0, wr_addr}, {20'b0, v.exp_addr[v.n-1]});
        check({tag, "_hold_data"}, {13'b0, wr_data}, {13'b0, v.exp_data[v.n-1]});
        check({tag, "_busy_idle"}, {31'b0, busy}, 32'd0);
        check({tag, "_chk_err"}, {31'b0, chk_err}, {31'b0, exp_chk});
    endtask

    initial begin
        // single word, burst with B2 upper bits set, wrap with header upper nibbles set, burst with gaps + stray start
        vecs[0] = make_vec(12'h002, 12'h000, 8'h00, 8'h00, 1, 19'h01A2F, 19'h0, 19'h0,
                           12'h002, 12'h000, 12'h000, 1'b0, 1'b0);
        vecs[1] = make_vec(12'h014, 12'h002, 8'h00, 8'hF8, 3, 19'h41234, 19'h00005, 19'h7FFFF,
                           12'h014, 12'h015, 12'h016, 1'b0, 1'b0);
        vecs[2] = make_vec(12'hFFF, 12'h001, 8'hF0, 8'h00, 2, 19'h12345, 19'h00ABC, 19'h0,
                           12'hFFF, 12'h000, 12'h000, 1'b0, 1'b0);
        vecs[3] = make_vec(12'h014, 12'h002, 8'h00, 8'hF8, 3, 19'h41234, 19'h00005, 19'h7FFFF,
                           12'h014, 12'h015, 12'h016, 1'b1, 1'b1);

        rst = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        #1;
        check("rst_busy",     {31'b0, busy},     32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd0);
        check("rst_wr_en",    {31'b0, wr_en},    32'd0);
        check("rst_done",     {31'b0, done},     32'd0);
        check("rst_chk_err",  {31'b0, chk_err},  32'd0);
        check("rst_wr_addr",  {20'b0, wr_addr},  32'd0);
        check("rst_wr_data",  {13'b0, wr_data},  32'd0);
        #21 rst = 1'b1;
        @(posedge clk); #1;

        for (int k = 0; k < 4; k++) begin
            run_session(vecs[k], 1'b0);
            check_vec($sformatf("vec%0d", k), vecs[k], 1'b0);
        end

        // abort with the last word's B2 byte still pending
        wq_addr.delete();
        wq_data.delete();
        pulse_start();
        send_byte(8'h02); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h2F); send_byte(8'h1A);
        in_data = 8'h00;
        check("pre_abort_in_ready", {31'b0, in_ready}, 32'd1);
        #2 rst = 1'b0;
        #1;
        check("abort_busy",     {31'b0, busy},     32'd0);
        check("abort_in_ready", {31'b0, in_ready}, 32'd0);
        check("abort_wr_en",    {31'b0, wr_en},    32'd0);
        check("abort_wr_addr",  {20'b0, wr_addr},  32'd0);
        check("abort_wr_data",  {13'b0, wr_data},  32'd0);
        in_valid = 1'b0;
        @(posedge clk); #3;
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort_no_write", wq_addr.size(), 32'd0);
        run_session(vecs[0], 1'b0);
        check_vec("after_abort", vecs[0], 1'b0);

`ifdef LOADER_CHECKSUM_EN
        run_session(vecs[0], 1'b1);
        check_vec("chk_bad", vecs[0], 1'b1);
        run_session(vecs[0], 1'b0);
        check_vec("chk_good", vecs[0], 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
